// File: rtl/rf_write_arbiter.sv
// Two-requester round-robin arbiter that feeds the single write port of the 8x8 register_file.
// Each requester owns a 1-entry buffer; one buffered write is issued per cycle on registered outputs.
module rf_write_arbiter #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          WEN,
    output logic [AW-1:0] RW,
    output logic [DW-1:0] busW,
    output logic          gnt_id,
    output logic          busy
);

    logic          r_full0;
    logic          r_full1;
    logic [AW-1:0] r_addr0;
    logic [AW-1:0] r_addr1;
    logic [DW-1:0] r_data0;
    logic [DW-1:0] r_data1;
    logic          r_last;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_gntAny;
    logic          w_take0;
    logic          w_take1;

    // On a tie the requester that was not granted last wins; r_last resets to 1 so 0 wins first.
    assign w_gnt0   = r_full0 && (!r_full1 || r_last);
    assign w_gnt1   = r_full1 && (!r_full0 || !r_last);
    assign w_gntAny = w_gnt0 || w_gnt1;

    assign req0_ready = !r_full0 || w_gnt0;
    assign req1_ready = !r_full1 || w_gnt1;
    assign w_take0    = req0_valid && req0_ready;
    assign w_take1    = req1_valid && req1_ready;

    assign busy = r_full0 || r_full1 || WEN;

    // A new transfer refills the buffer even while it is being drained this cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_full0 <= 1'b0;
            r_full1 <= 1'b0;
            r_addr0 <= '0;
            r_addr1 <= '0;
            r_data0 <= '0;
            r_data1 <= '0;
        end else begin
            if (w_take0) begin
                r_full0 <= 1'b1;
                r_addr0 <= req0_addr;
                r_data0 <= req0_data;
            end else if (w_gnt0) begin
                r_full0 <= 1'b0;
            end
            if (w_take1) begin
                r_full1 <= 1'b1;
                r_addr1 <= req1_addr;
                r_data1 <= req1_data;
            end else if (w_gnt1) begin
                r_full1 <= 1'b0;
            end
        end
    end

    // Address, data and grant id hold their last values while no write is issued.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            WEN    <= 1'b0;
            RW     <= '0;
            busW   <= '0;
            gnt_id <= 1'b0;
            r_last <= 1'b1;
        end else begin
            WEN <= w_gntAny;
            if (w_gntAny) begin
                RW     <= w_gnt1 ? r_addr1 : r_addr0;
                busW   <= w_gnt1 ? r_data1 : r_data0;
                gnt_id <= w_gnt1;
                r_last <= w_gnt1;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a behavioural register_file model on the write port.
// Inputs change just after the falling edge; outputs are sampled at the falling edge.
module tb_rf_write_arbiter;

    localparam int AW = 3;
    localparam int DW = 8;

    logic          Clk;
    logic          Rst;
    logic          req0_valid;
    logic          req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req1_valid;
    logic          req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          WEN;
    logic [AW-1:0] RW;
    logic [DW-1:0] busW;
    logic          gnt_id;
    logic          busy;

    logic          initRegs;
    logic [DW-1:0] regModel [8];

    int errorCount;
    int checkCount;
    int wenCount;
    int gnt0Count;
    int gnt1Count;

    rf_write_arbiter #(.AW(AW), .DW(DW)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .WEN        (WEN),
        .RW         (RW),
        .busW       (busW),
        .gnt_id     (gnt_id),
        .busy       (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register file stand-in: preloaded with E0+i, then written from the arbiter's port.
    always @(posedge Clk) begin
        if (initRegs) begin
            for (int i = 0; i < 8; i++) regModel[i] <= 8'hE0 + 8'(i);
        end else if (WEN) begin
            regModel[RW] <= busW;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0_valid = v0;
        req0_addr  = a0;
        req0_data  = d0;
        req1_valid = v1;
        req1_addr  = a1;
        req1_data  = d1;
    endtask

    task automatic pulseReset();
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    initial begin
        errorCount = 0;
        checkCount = 0;
        Rst        = 1'b1;
        initRegs   = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);

        @(negedge Clk);
        checkOutput("rst_wen", WEN, 0);
        checkOutput("rst_rw", RW, 0);
        checkOutput("rst_busw", busW, 0);
        checkOutput("rst_gnt", gnt_id, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready0", req0_ready, 1);
        checkOutput("rst_ready1", req1_ready, 1);
        @(negedge Clk);
        initRegs = 1'b0;
        Rst      = 1'b0;

        // Reset arriving mid-cycle with both buffers full discards both writes.
        applyStimulus(1, 6, 8'h66, 1, 7, 8'h77);
        @(negedge Clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("prerst_busy", busy, 1);
        checkOutput("prerst_ready1", req1_ready, 0);
        #1 Rst = 1'b1;
        #1;
        checkOutput("midrst_wen", WEN, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_ready0", req0_ready, 1);
        checkOutput("midrst_ready1", req1_ready, 1);
        @(negedge Clk);
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        checkOutput("midrst_reg6", regModel[6], 8'hE6);
        checkOutput("midrst_reg7", regModel[7], 8'hE7);

        // Single write from requester 0.
        applyStimulus(1, 3, 8'hA5, 0, 0, 0);
        checkOutput("single_ready0", req0_ready, 1);
        @(negedge Clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("single_wen_early", WEN, 0);
        @(negedge Clk);
        checkOutput("single_wen", WEN, 1);
        checkOutput("single_rw", RW, 3);
        checkOutput("single_busw", busW, 8'hA5);
        checkOutput("single_gnt", gnt_id, 0);
        @(negedge Clk);
        checkOutput("single_wen_off", WEN, 0);
        checkOutput("single_reg3", regModel[3], 8'hA5);

        // First tie after reset goes to requester 0.
        pulseReset();
        applyStimulus(1, 2, 8'h11, 1, 5, 8'h22);
        @(negedge Clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("tie_ready0", req0_ready, 1);
        checkOutput("tie_ready1", req1_ready, 0);
        @(negedge Clk);
        checkOutput("tie_first_gnt", gnt_id, 0);
        checkOutput("tie_first_rw", RW, 2);
        checkOutput("tie_ready1_next", req1_ready, 1);
        @(negedge Clk);
        checkOutput("tie_second_wen", WEN, 1);
        checkOutput("tie_second_gnt", gnt_id, 1);
        checkOutput("tie_second_busw", busW, 8'h22);
        @(negedge Clk);
        checkOutput("tie_reg2", regModel[2], 8'h11);
        checkOutput("tie_reg5", regModel[5], 8'h22);

        // Prior grant to requester 0, then a same-address race goes to requester 1 first.
        applyStimulus(1, 0, 8'h33, 0, 0, 0);
        @(negedge Clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge Clk);
        applyStimulus(1, 4, 8'h01, 1, 4, 8'h02);
        @(negedge Clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        checkOutput("race_first_gnt", gnt_id, 1);
        checkOutput("race_first_busw", busW, 8'h02);
        @(negedge Clk);
        checkOutput("race_second_gnt", gnt_id, 0);
        checkOutput("race_second_busw", busW, 8'h01);
        @(negedge Clk);
        checkOutput("race_reg4", regModel[4], 8'h01);

        // Requester 0 streams 8 back-to-back writes.
        wenCount = 0;
        for (int c = 0; c < 11; c++) begin
            if (c >= 2 && c < 10) begin
                checkOutput("stream_rw", RW, c - 2);
                checkOutput("stream_busw", busW, 8'h10 + c - 2);
                if (WEN) wenCount++;
            end
            if (c == 10) checkOutput("stream_wen_end", WEN, 0);
            if (c < 8) begin
                checkOutput("stream_ready0", req0_ready, 1);
                applyStimulus(1, AW'(c), 8'h10 + 8'(c), 0, 0, 0);
            end else begin
                applyStimulus(0, 0, 0, 0, 0, 0);
            end
            @(negedge Clk);
        end
        checkOutput("stream_wen_count", wenCount, 8);
        for (int i = 0; i < 8; i++) checkOutput("stream_reg", regModel[i], 8'h10 + i);

        // Both requesters hold valid for 20 cycles: strict alternation starting with 0.
        pulseReset();
        wenCount  = 0;
        gnt0Count = 0;
        gnt1Count = 0;
        for (int c = 0; c < 22; c++) begin
            if (c >= 2) begin
                checkOutput("fair_gnt", gnt_id, (c - 2) % 2);
                if (WEN) begin
                    wenCount++;
                    if (gnt_id) gnt1Count++;
                    else gnt0Count++;
                end
            end
            if (c < 20) applyStimulus(1, 0, 8'h40 + 8'(c), 1, 1, 8'h80 + 8'(c));
            else applyStimulus(0, 0, 0, 0, 0, 0);
            @(negedge Clk);
        end
        checkOutput("fair_wen_count", wenCount, 20);
        checkOutput("fair_gnt0_count", gnt0Count, 10);
        checkOutput("fair_gnt1_count", gnt1Count, 10);
        repeat (4) @(negedge Clk);
        checkOutput("fair_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
